pe_result_collector: RTL and testbench

Readback engine for the 25-PE array: the return path of the memory-to-PE broadcast. On a start pulse it walks PE indices 0..NUM_PE-1, asserts a one-hot read-select per PE, captures that PE's 8-bit result, and streams it out over a single valid/ready bus. It sits between the PE array outputs and the result sink, such as a result memory or host interface.

---
 rtl/pe_array_pkg.sv | 16 +
 rtl/pe_read_select.sv | 21 ++
 rtl/pe_result_collector.sv | 80 ++++++++
 tb/tb_pe_result_collector.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared constants and collector state encoding for the 25-PE array.
package pe_array_pkg;
  localparam int NUM_PE         = 25;
  localparam int DATA_WIDTH     = 8;
  localparam int ADDR_WIDTH     = 5;
  localparam int CHECKSUM_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_OUT,
    ST_DONE
  } collect_state_e;
endpackage

// File: rtl/pe_read_select.sv
// Combinational PE read decoder: one-hot read-select plus muxed PE result for idx.
module pe_read_select
  import pe_array_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0]        idx,
  input  logic                         en,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_data,
  output logic [NUM_PE-1:0]            re_lines,
  output logic [DATA_WIDTH-1:0]        sel_data
);
  always_comb begin
    re_lines = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (idx == ADDR_WIDTH'(i)) begin
        re_lines[i] = en;
        sel_data    = pe_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: rtl/pe_result_collector.sv
// Walks PEs 0..NUM_PE-1, captures each result and streams it over valid/ready.
// Optional running checksum of the pass: define PE_COLLECT_CHECKSUM_EN.
module pe_result_collector
  import pe_array_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_data,
  output logic [NUM_PE-1:0]            re_lines,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic                         busy,
  output logic                         done
`ifdef PE_COLLECT_CHECKSUM_EN
  ,
  output logic [CHECKSUM_WIDTH-1:0]    checksum
`endif
);
  collect_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    handshake;

  pe_read_select u_read_select (
    .idx      (idx),
    .en       (state == ST_SELECT),
    .pe_data  (pe_data),
    .re_lines (re_lines),
    .sel_data (sel_data)
  );

  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SELECT;
      ST_SELECT: state_next = ST_OUT;
      ST_OUT:    if (out_ready) state_next = (idx == LAST_IDX) ? ST_DONE : ST_SELECT;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      out_data <= '0;
      out_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) idx <= '0;
      // Capture point: the PE is selected for exactly one cycle.
      if (state == ST_SELECT) begin
        out_data <= sel_data;
        out_addr <= idx;
      end
      if (handshake && idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

`ifdef PE_COLLECT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == ST_IDLE && start) begin
      checksum <= '0;
    end else if (handshake) begin
      checksum <= checksum + CHECKSUM_WIDTH'(out_data);
    end
  end
`endif
endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector; checksum checks active with PE_COLLECT_CHECKSUM_EN.
module tb_pe_result_collector;
  import pe_array_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         start = 1'b0;
  logic [NUM_PE*DATA_WIDTH-1:0] pe_data = '0;
  logic [NUM_PE-1:0]            re_lines;
  logic                         out_valid;
  logic                         out_ready = 1'b0;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [ADDR_WIDTH-1:0]        out_addr;
  logic                         busy;
  logic                         done;
`ifdef PE_COLLECT_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0]    checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] beat_data[$];
  logic [ADDR_WIDTH-1:0] beat_addr[$];
  int                    done_at[$];
  int                    onehot_bad;
  int                    stall_bad;
  int                    stall_cnt;
  int                    sel_cnt;
  logic [DATA_WIDTH-1:0] exp_data[NUM_PE];

  pe_result_collector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pe_data   (pe_data),
    .re_lines  (re_lines),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done)
`ifdef PE_COLLECT_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pes(input bit all_ff);
    for (int i = 0; i < NUM_PE; i++) begin
      exp_data[i] = all_ff ? 8'hFF : DATA_WIDTH'(i);
      pe_data[i*DATA_WIDTH +: DATA_WIDTH] = exp_data[i];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observes the bus from the sample just after the start edge (index 0)
  // until the requested number of done pulses; records beats and anomalies.
  task automatic collect(input bit toggle, input bit hold_start, input bit restart10,
                         input int passes, input int max_cycles, output bit timed_out);
    logic [NUM_PE-1:0]     one;
    logic [DATA_WIDTH-1:0] prev_data;
    logic [ADDR_WIDTH-1:0] prev_addr;
    bit                    prev_stall;
    beat_data.delete();
    beat_addr.delete();
    done_at.delete();
    onehot_bad = 0;
    stall_bad  = 0;
    stall_cnt  = 0;
    sel_cnt    = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    timed_out  = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_addr !== prev_addr))
        stall_bad++;
      if (re_lines != '0) begin
        sel_cnt++;
        one = 1;
        one = one << (beat_data.size() % NUM_PE);
        if (out_valid || done || re_lines !== one) onehot_bad++;
      end
      if (done) done_at.push_back(n);
      out_ready = toggle ? ((n % 2) == 0) : 1'b1;
      start = hold_start || (restart10 && out_valid && beat_data.size() == 10);
      if (out_valid && out_ready) begin
        beat_data.push_back(out_data);
        beat_addr.push_back(out_addr);
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cnt++;
      prev_data = out_data;
      prev_addr = out_addr;
      if (done_at.size() == passes) begin
        start = 1'b0;
        tick();
        out_ready = 1'b0;
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_beats(input string name, input int exp_count);
    checks++;
    if (beat_data.size() != exp_count) begin
      errors++;
      $display("FAIL %s beat_count: got %0d expected %0d", name, beat_data.size(), exp_count);
    end
    for (int i = 0; i < beat_data.size() && i < exp_count; i++) begin
      checks++;
      if (beat_addr[i] !== ADDR_WIDTH'(i % NUM_PE) || beat_data[i] !== exp_data[i % NUM_PE]) begin
        errors++;
        $display("FAIL %s beat%0d: got addr %0d data 0x%02h expected addr %0d data 0x%02h",
                 name, i, beat_addr[i], beat_data[i], i % NUM_PE, exp_data[i % NUM_PE]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (re_lines !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got re=%h v=%b d=%h a=%h busy=%b done=%b expected all zero",
               re_lines, out_valid, out_data, out_addr, busy, done);
    end
`ifdef PE_COLLECT_CHECKSUM_EN
    checks++;
    if (checksum !== 16'd0) begin
      errors++;
      $display("FAIL reset_checksum: got %0d expected 0", checksum);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sequential();
    bit to;
    load_pes(1'b0);
    pulse_start();
    collect(1'b0, 1'b0, 1'b0, 1, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL seq_timeout: no done within bound"); end
    check_beats("seq", NUM_PE);
    checks++;
    if (done_at.size() != 1 || done_at[0] != 50) begin
      errors++;
      $display("FAIL seq_done_timing: got %0d pulses first at %0d expected 1 at 50",
               done_at.size(), done_at.size() ? done_at[0] : -1);
    end
    checks++;
    if (onehot_bad != 0 || sel_cnt != NUM_PE) begin
      errors++;
      $display("FAIL seq_re_lines: got %0d bad, %0d selects expected 0 bad, 25 selects",
               onehot_bad, sel_cnt);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL seq_idle_after: got busy=%b done=%b expected 0 0", busy, done);
    end
`ifdef PE_COLLECT_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h012C) begin
      errors++;
      $display("FAIL seq_checksum: got 0x%04h expected 0x012c", checksum);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit to;
    load_pes(1'b0);
    pulse_start();
    collect(1'b1, 1'b0, 1'b0, 1, 400, to);
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout: no done within bound"); end
    check_beats("bp", NUM_PE);
    checks++;
    if (stall_bad != 0 || stall_cnt == 0) begin
      errors++;
      $display("FAIL bp_stall_stable: got %0d unstable of %0d stalls expected 0 of >0",
               stall_bad, stall_cnt);
    end
    checks++;
    if (done_at.size() != 1) begin
      errors++;
      $display("FAIL bp_done_count: got %0d expected 1", done_at.size());
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    load_pes(1'b0);
    pulse_start();
    collect(1'b0, 1'b0, 1'b1, 1, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL restart_timeout: no done within bound"); end
    check_beats("restart", NUM_PE);
    checks++;
    if (done_at.size() != 1 || done_at[0] != 50) begin
      errors++;
      $display("FAIL restart_done: got %0d pulses first at %0d expected 1 at 50",
               done_at.size(), done_at.size() ? done_at[0] : -1);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_queue: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit to;
    bit found;
    bit saw_done;
    load_pes(1'b0);
    pulse_start();
    found = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (out_valid && out_addr == 5'd7) begin found = 1'b1; break; end
      out_ready = 1'b1;
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reach_beat7: got no beat 7 expected one"); end
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (re_lines !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: got re=%h v=%b d=%h a=%h busy=%b done=%b expected all zero",
               re_lines, out_valid, out_data, out_addr, busy, done);
    end
`ifdef PE_COLLECT_CHECKSUM_EN
    checks++;
    if (checksum !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_checksum: got %0d expected 0", checksum);
    end
`endif
    for (int n = 0; n < 5; n++) begin
      out_ready = 1'b1;
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (saw_done) begin errors++; $display("FAIL mid_no_done: got activity after reset expected none"); end
    pulse_start();
    collect(1'b0, 1'b0, 1'b0, 1, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL mid_restart_timeout: no done within bound"); end
    check_beats("mid_restart", NUM_PE);
  endtask

  task automatic test_all_ff();
    bit to;
    load_pes(1'b1);
    pulse_start();
    collect(1'b0, 1'b0, 1'b0, 1, 200, to);
    checks++;
    if (to) begin errors++; $display("FAIL ff_timeout: no done within bound"); end
    check_beats("ff", NUM_PE);
    checks++;
    if (onehot_bad != 0 || sel_cnt != NUM_PE) begin
      errors++;
      $display("FAIL ff_re_lines: got %0d bad, %0d selects expected 0 bad, 25 selects",
               onehot_bad, sel_cnt);
    end
`ifdef PE_COLLECT_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h18E7) begin
      errors++;
      $display("FAIL ff_checksum: got 0x%04h expected 0x18e7", checksum);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit to;
    load_pes(1'b0);
    start = 1'b1;
    tick();
    collect(1'b0, 1'b1, 1'b0, 2, 300, to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_timeout: two passes not done within bound"); end
    check_beats("b2b", 2 * NUM_PE);
    checks++;
    if (done_at.size() != 2 || done_at[0] != 50 || done_at[1] != 102) begin
      errors++;
      $display("FAIL b2b_done_timing: got %0d pulses at %0d,%0d expected 2 at 50,102",
               done_at.size(), done_at.size() > 0 ? done_at[0] : -1,
               done_at.size() > 1 ? done_at[1] : -1);
    end
    checks++;
    if (onehot_bad != 0 || sel_cnt != 2 * NUM_PE) begin
      errors++;
      $display("FAIL b2b_re_lines: got %0d bad, %0d selects expected 0 bad, 50 selects",
               onehot_bad, sel_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_pass();
    test_all_ff();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
